// File: rtl/vga_timing_gen.sv
// VGA raster generator: free-running pixel/line counters with registered sync, blank and vblank decode.
// All decode works on the next counter values, so every output changes on the same edge as DrawX/DrawY.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       vblank_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_sizeCheck
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
        end
    endgenerate

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] r_drawX;
    logic [9:0] r_drawY;
    logic       r_blank;
    logic       r_hs;
    logic       r_vs;
    logic       r_vblankStart;

    logic [9:0] w_nextX;
    logic [9:0] w_nextY;
    logic       w_blank;
    logic       w_hs;
    logic       w_vs;
    logic       w_vblankStart;

    // DrawY only moves on the DrawX wrap.
    always_comb begin
        w_nextX = r_drawX + 10'd1;
        w_nextY = r_drawY;
        if (r_drawX == H_LAST) begin
            w_nextX = '0;
            if (r_drawY == V_LAST) begin
                w_nextY = '0;
            end else begin
                w_nextY = r_drawY + 10'd1;
            end
        end
    end

    always_comb begin
        w_blank       = (w_nextX < H_VIS) && (w_nextY < V_VIS);
        w_hs          = !((w_nextX >= HS_START) && (w_nextX < HS_END));
        w_vs          = !((w_nextY >= VS_START) && (w_nextY < VS_END));
        w_vblankStart = (w_nextX == 10'd0) && (w_nextY == V_VIS);
    end

    // Reset drops sync pulses immediately; no partial pulse survives.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drawX       <= '0;
            r_drawY       <= '0;
            r_blank       <= 1'b1;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_vblankStart <= 1'b0;
        end else begin
            r_drawX       <= w_nextX;
            r_drawY       <= w_nextY;
            r_blank       <= w_blank;
            r_hs          <= w_hs;
            r_vs          <= w_vs;
            r_vblankStart <= w_vblankStart;
        end
    end

    assign DrawX        = r_drawX;
    assign DrawY        = r_drawY;
    assign blank        = r_blank;
    assign hs           = r_hs;
    assign vs           = r_vs;
    assign vblank_start = r_vblankStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance checked against a hand-computed vector table,
// and a tiny-raster instance (15x11) checked over whole frames against a reference raster.
module tb_vga_timing_gen;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;

    logic [9:0] aX, aY;
    logic       aBlank, aHs, aVs, aVbs;
    logic [9:0] bX, bY;
    logic       bBlank, bHs, bVs, bVbs;

    int unsigned cyc;
    int          vectorsApplied = 0;
    int          miscompares    = 0;

    // Small raster: 8+2+3+2 = 15 pixels, 6+2+2+1 = 11 lines, 165 cycles per frame.
    localparam int B_HT    = 15;
    localparam int B_VT    = 11;
    localparam int B_FRAME = B_HT * B_VT;

    vga_timing_gen dutA (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (aX),
        .DrawY       (aY),
        .blank       (aBlank),
        .hs          (aHs),
        .vs          (aVs),
        .vblank_start(aVbs)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(1)
    ) dutB (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (bX),
        .DrawY       (bY),
        .blank       (bBlank),
        .hs          (bHs),
        .vs          (bVs),
        .vblank_start(bVbs)
    );

    always #5 vga_clk = ~vga_clk;

    // Rising edges since the last reset release; this is the reference raster position.
    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct {
        int unsigned k;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        vbs;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int unsigned k);
        int guard;
        guard = 0;
        while (cyc < k && guard < 5000) begin
            @(negedge vga_clk);
            guard++;
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " A"}, {8'h0, aX, aY, aBlank, aHs, aVs, aVbs}, {8'h0, 10'd0, 10'd0, 4'b1110});
        checkOutput({tag, " B"}, {8'h0, bX, bY, bBlank, bHs, bVs, bVbs}, {8'h0, 10'd0, 10'd0, 4'b1110});
    endtask

    task automatic runFrames(input int nFrames, input string tag);
        int unsigned k, mx, my;
        int  modelErr, blankCnt, hsLow, vsLow, pulses, spacingErr;
        longint lastPulse;
        logic eBlank, eHs, eVs, eVbs;
        modelErr = 0; blankCnt = 0; hsLow = 0; vsLow = 0; pulses = 0; spacingErr = 0;
        lastPulse = -1;
        for (int i = 0; i < nFrames * B_FRAME; i++) begin
            @(negedge vga_clk);
            k      = cyc;
            mx     = k % B_HT;
            my     = (k / B_HT) % B_VT;
            eBlank = (mx < 8) && (my < 6);
            eHs    = !(mx >= 10 && mx < 13);
            eVs    = !(my >= 8 && my < 10);
            eVbs   = (mx == 0) && (my == 6);
            if ({bX, bY, bBlank, bHs, bVs, bVbs} !== {10'(mx), 10'(my), eBlank, eHs, eVs, eVbs})
                modelErr++;
            if (bBlank === 1'b1) blankCnt++;
            if (bHs === 1'b0) hsLow++;
            if (bVs === 1'b0) vsLow++;
            if (bVbs === 1'b1) begin
                pulses++;
                if (lastPulse >= 0 && (longint'(k) - lastPulse) != B_FRAME) spacingErr++;
                lastPulse = longint'(k);
            end
        end
        checkOutput({tag, " raster cycles off model"}, modelErr, 0);
        checkOutput({tag, " blank high count"}, blankCnt, nFrames * 48);
        checkOutput({tag, " hs low count"}, hsLow, nFrames * 33);
        checkOutput({tag, " vs low count"}, vsLow, nFrames * 30);
        checkOutput({tag, " vblank_start pulses"}, pulses, nFrames);
        checkOutput({tag, " vblank_start spacing errors"}, spacingErr, 0);
    endtask

    initial begin
        int found;

        // {k, DrawX, DrawY, blank, hs, vs, vblank_start} for the 640x480 instance, k edges after release.
        vecs[0]  = '{1,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{2,    10'd2,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{639,  10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{640,  10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{655,  10'd655, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{656,  10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{751,  10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{752,  10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{799,  10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{800,  10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{801,  10'd1,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1456, 10'd656, 10'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1599, 10'd799, 10'd1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1600, 10'd0,   10'd2, 1'b1, 1'b1, 1'b1, 1'b0};

        $display("[TB] reset phase");
        reset_n = 1'b0;
        repeat (5) @(negedge vga_clk);
        checkReset("reset held");
        reset_n = 1'b1;

        $display("[TB] line timing table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].k);
            checkOutput($sformatf("line vec k=%0d", vecs[i].k),
                        {8'h0, aX, aY, aBlank, aHs, aVs, aVbs},
                        {8'h0, vecs[i].x, vecs[i].y, vecs[i].blank, vecs[i].hs, vecs[i].vs, vecs[i].vbs});
        end

        $display("[TB] three small frames");
        runFrames(3, "3 frames");

        $display("[TB] mid-sync async reset");
        found = 0;
        for (int i = 0; i < 2 * B_FRAME && found == 0; i++) begin
            @(negedge vga_clk);
            if (bX == 10'd11 && bY == 10'd9) found = 1;
        end
        checkOutput("reach (11,9) within budget", found, 1);
        checkOutput("sync low before reset", {30'h0, bHs, bVs}, 32'h0);
        #2 reset_n = 1'b0;
        #1 checkReset("async reset mid-sync");
        @(negedge vga_clk);
        checkReset("reset held over edge");
        reset_n = 1'b1;
        @(negedge vga_clk);
        checkOutput("first edge after release", {8'h0, bX, bY, bBlank, bHs, bVs, bVbs}, {8'h0, 10'd1, 10'd0, 4'b1110});
        runFrames(1, "post-reset frame");

        $display("[TB] frame wrap");
        found = 0;
        for (int i = 0; i < 2 * B_FRAME && found == 0; i++) begin
            @(negedge vga_clk);
            if (bX == 10'd14 && bY == 10'd10) found = 1;
        end
        checkOutput("reach (14,10) within budget", found, 1);
        @(negedge vga_clk);
        checkOutput("frame wrap", {8'h0, bX, bY, bBlank, bHs, bVs, bVbs}, {8'h0, 10'd0, 10'd0, 4'b1110});

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
